// File: rtl/timer_pkg.sv
// Shared definitions for the PWM timer command sequencer: state encoding,
// timer register addresses and the default stop-count ceiling.
package timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_MAX  = 3'd1,
    S_WR_PWM  = 3'd2,
    S_WR_STOP = 3'd3,
    S_START   = 3'd4,
    S_WAIT_HI = 3'd5,
    S_WAIT_LO = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_MAX  = 2'd0;
  localparam logic [1:0] ADDR_PWM  = 2'd1;
  localparam logic [1:0] ADDR_STOP = 2'd2;

  localparam int STOP_MAX_DEF = 127;

endpackage

// File: rtl/timer_cfg_seq.sv
// Command sequencer for the PWM timer: accepts a profile, writes the three
// timer registers, pulses start, then waits for the end burst to finish.
// A watchdog aborts a run whose end flag never rises.
module timer_cfg_seq
  import timer_pkg::*;
#(
  parameter int DW          = 16,
  parameter int STOP_MAX    = STOP_MAX_DEF,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TOW         = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [DW-1:0] i_cmd_max,
  input  logic [DW-1:0] i_cmd_pwm,
  input  logic [DW-1:0] i_cmd_stop,
  output logic          o_we,
  output logic [1:0]    o_addr,
  output logic [DW-1:0] o_wdata,
  output logic          o_start,
  input  logic          i_timer_end,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [7:0]    o_run_count
);

  localparam logic [DW-1:0]  LP_STOP_MAX = DW'(STOP_MAX);
  // The increment result is compared, so the abort decision lands on the
  // cycle before the error pulse and the pulse appears TIMEOUT_CYC cycles
  // after start.
  localparam logic [TOW-1:0] LP_WD_LAST  = TOW'(TIMEOUT_CYC - 1);

  // A profile is usable only with a non-zero period and a low phase that fits in it.
  function automatic logic cmd_ok_f(input logic [DW-1:0] mx, input logic [DW-1:0] pw);
    return (mx != '0) && (pw <= mx);
  endfunction

  // The timer's cycle counter cannot exceed STOP_MAX, so clamp rather than reject.
  function automatic logic [DW-1:0] sat_stop_f(input logic [DW-1:0] st);
    return (st > LP_STOP_MAX) ? LP_STOP_MAX : st;
  endfunction

  state_t          r_state, w_next;
  logic [DW-1:0]   r_pwm, r_stop;
  logic [TOW-1:0]  r_wd, w_wd_inc;
  logic            w_err;
  logic            r_ready, r_we, r_start, r_busy, r_done, r_err;
  logic [1:0]      r_addr;
  logic [DW-1:0]   r_wdata;
  logic [7:0]      r_run;

  // Next-state decode; w_err flags a rejected command or a watchdog abort.
  always_comb begin
    w_next   = r_state;
    w_err    = 1'b0;
    w_wd_inc = r_wd + 1'b1;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          if (cmd_ok_f(i_cmd_max, i_cmd_pwm)) w_next = S_WR_MAX;
          else                                w_err  = 1'b1;
        end
      end
      S_WR_MAX:  w_next = S_WR_PWM;
      S_WR_PWM:  w_next = S_WR_STOP;
      S_WR_STOP: w_next = S_START;
      S_START:   w_next = S_WAIT_HI;
      S_WAIT_HI: begin
        // End has priority over a simultaneous timeout.
        if (i_timer_end) begin
          w_next = S_WAIT_LO;
        end else if (w_wd_inc == LP_WD_LAST) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WAIT_LO: if (!i_timer_end) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Command latches and watchdog; max is forwarded straight from the input at accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm  <= '0;
      r_stop <= '0;
      r_wd   <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_WR_MAX) begin
        r_pwm  <= i_cmd_pwm;
        r_stop <= sat_stop_f(i_cmd_stop);
      end
      if (r_state == S_START)        r_wd <= '0;
      else if (r_state == S_WAIT_HI) r_wd <= w_wd_inc;
    end
  end

  // Moore outputs registered from the next state so they align with the state they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= 2'd0;
      r_wdata <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_run   <= 8'd0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_start <= (w_next == S_START);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_err   <= w_err;
      r_we    <= 1'b0;
      r_addr  <= 2'd0;
      r_wdata <= '0;
      case (w_next)
        S_WR_MAX:  begin r_we <= 1'b1; r_addr <= ADDR_MAX;  r_wdata <= i_cmd_max; end
        S_WR_PWM:  begin r_we <= 1'b1; r_addr <= ADDR_PWM;  r_wdata <= r_pwm;     end
        S_WR_STOP: begin r_we <= 1'b1; r_addr <= ADDR_STOP; r_wdata <= r_stop;    end
        default:   ;
      endcase
      if (w_next == S_DONE) r_run <= r_run + 8'd1;
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_we        = r_we;
  assign o_addr      = r_addr;
  assign o_wdata     = r_wdata;
  assign o_start     = r_start;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_run_count = r_run;

endmodule

// File: tb/tb_timer_cfg_seq.sv
// Bench for timer_cfg_seq: table of command vectors plus hand-written
// sequences for timeout, end/timeout race, held commands, count wrap and
// reset in the middle of programming.
module tb_timer_cfg_seq;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_max, cmd_pwm, cmd_stop;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        start, timer_end, busy, done, err;
  logic [7:0]  run_count;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_run = 8'd0;

  timer_cfg_seq #(.DW(16), .STOP_MAX(127), .TIMEOUT_CYC(20), .TOW(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_max(cmd_max), .i_cmd_pwm(cmd_pwm), .i_cmd_stop(cmd_stop),
    .o_we(we), .o_addr(addr), .o_wdata(wdata), .o_start(start),
    .i_timer_end(timer_end), .o_busy(busy), .o_done(done), .o_err(err),
    .o_run_count(run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Present a command at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic accept(input logic [15:0] mx, input logic [15:0] pw, input logic [15:0] st,
                        input bit hold);
    cmd_valid = 1'b1;
    cmd_max   = mx;
    cmd_pwm   = pw;
    cmd_stop  = st;
    chk("ready_at_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic run_reject(input logic [15:0] mx, input logic [15:0] pw, input logic [15:0] st);
    accept(mx, pw, st, 1'b0);
    chk("rej_err",   32'(err),       32'd1);
    chk("rej_we",    32'(we),        32'd0);
    chk("rej_ready", 32'(cmd_ready), 32'd1);
    chk("rej_busy",  32'(busy),      32'd0);
    @(negedge clk);
    chk("rej_err_clr", 32'(err),   32'd0);
    chk("rej_start",   32'(start), 32'd0);
    chk("rej_we2",     32'(we),    32'd0);
  endtask

  // Full profile: end rises h cycles into WAIT_HI and stays high b cycles.
  task automatic run_ok(input logic [15:0] mx, input logic [15:0] pw, input logic [15:0] st,
                        input logic [15:0] wst, input int h, input int b, input bit hold);
    accept(mx, pw, st, hold);
    chk("wr0_we", 32'(we), 32'd1); chk("wr0_addr", 32'(addr), 32'd0);
    chk("wr0_data", 32'(wdata), 32'(mx)); chk("wr0_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("wr1_we", 32'(we), 32'd1); chk("wr1_addr", 32'(addr), 32'd1);
    chk("wr1_data", 32'(wdata), 32'(pw));
    @(negedge clk);
    chk("wr2_we", 32'(we), 32'd1); chk("wr2_addr", 32'(addr), 32'd2);
    chk("wr2_data", 32'(wdata), 32'(wst));
    @(negedge clk);
    chk("start_pulse", 32'(start), 32'd1); chk("start_we", 32'(we), 32'd0);
    chk("start_addr", 32'(addr), 32'd0);   chk("start_wdata", 32'(wdata), 32'd0);
    @(negedge clk);
    chk("start_clr", 32'(start), 32'd0); chk("wait_busy", 32'(busy), 32'd1);
    repeat (h) @(negedge clk);
    timer_end = 1'b1;
    for (int i = 0; i < b; i++) begin
      @(negedge clk);
      chk("burst_err", 32'(err), 32'd0); chk("burst_done", 32'(done), 32'd0);
      chk("burst_ready", 32'(cmd_ready), 32'd0);
    end
    timer_end = 1'b0;
    @(negedge clk);
    exp_run = exp_run + 8'd1;
    chk("done_pulse", 32'(done), 32'd1); chk("done_busy", 32'(busy), 32'd1);
    chk("run_count", 32'(run_count), 32'(exp_run));
    @(negedge clk);
    chk("done_clr", 32'(done), 32'd0); chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [15:0] mx, pw, st, wst;
    bit          ok;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{mx:16'd10,     pw:16'd4,      st:16'd3,      wst:16'd3,   ok:1'b1};
    vt[1] = '{mx:16'd5,      pw:16'd6,      st:16'd2,      wst:16'd0,   ok:1'b0};
    vt[2] = '{mx:16'd20,     pw:16'd5,      st:16'd300,    wst:16'd127, ok:1'b1};
    vt[3] = '{mx:16'd0,      pw:16'd0,      st:16'd1,      wst:16'd0,   ok:1'b0};
    vt[4] = '{mx:16'd7,      pw:16'd7,      st:16'd127,    wst:16'd127, ok:1'b1};
    vt[5] = '{mx:16'd9,      pw:16'd0,      st:16'd128,    wst:16'd127, ok:1'b1};
    vt[6] = '{mx:16'hFFFF,   pw:16'hFFFF,   st:16'hFFFF,   wst:16'd127, ok:1'b1};
    vt[7] = '{mx:16'd1,      pw:16'd2,      st:16'd0,      wst:16'd0,   ok:1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_max = '0; cmd_pwm = '0; cmd_stop = '0;
    timer_end = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1); chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);       chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_start", 32'(start), 32'd0);     chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);       chk("rst_err", 32'(err), 32'd0);
    chk("rst_run", 32'(run_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].ok) run_ok(vt[i].mx, vt[i].pw, vt[i].st, vt[i].wst, 2, 10, 1'b0);
      else          run_reject(vt[i].mx, vt[i].pw, vt[i].st);
    end

    // Valid held through the first profile: second accepted only once idle again.
    run_ok(16'd4, 16'd2, 16'd1, 16'd1, 1, 3, 1'b1);
    run_ok(16'd4, 16'd2, 16'd1, 16'd1, 1, 3, 1'b0);

    // End in first WAIT_HI cycle, and end on the last cycle before the watchdog fires.
    run_ok(16'd6, 16'd3, 16'd2, 16'd2, 0, 2, 1'b0);
    run_ok(16'd6, 16'd3, 16'd2, 16'd2, 18, 3, 1'b0);

    // Watchdog: timer never ends; error 20 cycles after start.
    accept(16'd3, 16'd1, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    chk("to_start", 32'(start), 32'd1);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      chk("to_wait_err", 32'(err), 32'd0);
      chk("to_wait_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);       chk("to_busy", 32'(busy), 32'd0);
    chk("to_ready", 32'(cmd_ready), 32'd1); chk("to_done", 32'(done), 32'd0);
    chk("to_run", 32'(run_count), 32'(exp_run));
    @(negedge clk);
    chk("to_err_clr", 32'(err), 32'd0);

    // Run until the completion count wraps to zero.
    while (exp_run != 8'hFF) run_ok(16'd8, 16'd3, 16'd5, 16'd5, 1, 1, 1'b0);
    run_ok(16'd8, 16'd3, 16'd5, 16'd5, 1, 1, 1'b0);
    chk("run_wrap", 32'(run_count), 32'd0);
    run_ok(16'd8, 16'd3, 16'd5, 16'd5, 1, 1, 1'b0);

    // Asynchronous reset while writing the pwm register.
    accept(16'd10, 16'd4, 16'd3, 1'b0);
    @(negedge clk);
    chk("mid_we", 32'(we), 32'd1); chk("mid_addr", 32'(addr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(we), 32'd0);       chk("arst_addr", 32'(addr), 32'd0);
    chk("arst_wdata", 32'(wdata), 32'd0); chk("arst_start", 32'(start), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);   chk("arst_run", 32'(run_count), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_run = 8'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_we", 32'(we), 32'd0);       chk("post_start", 32'(start), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);   chk("post_ready", 32'(cmd_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
